// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter.
//
// Sends a WIDTH-bit pattern MSB-first, one bit per clock, repeated `count`
// times. GAP idle cycles are inserted between repetitions. The pattern and
// count are captured when start is accepted, so later changes on those inputs
// do not affect a transfer that is already running.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset; returns to idle immediately
//   start   - transfer request, sampled only while idle
//   abort   - synchronous cancel, honoured in any non-idle state
//   pattern - pattern to send, latched when start is accepted
//   count   - number of repetitions, latched with pattern; 0 is ignored
//   out     - serial data bit (0 when not shifting)
//   valid   - out carries a pattern bit
//   busy    - transfer in progress (shift or gap)
//   done    - one-cycle pulse after the last bit of the last repetition
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] count,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  // Counter widths: the bit counter holds WIDTH-1 and the gap counter holds GAP-1.
  localparam int unsigned BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [BW-1:0]    BitLoad = BW'(WIDTH - 1);
  localparam logic [GW-1:0]    GapLoad = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [BW-1:0]    BitOne  = BW'(1);
  localparam logic [GW-1:0]    GapOne  = GW'(1);
  localparam logic [CNT_W-1:0] RepOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] pat_q;
  logic [BW-1:0]    bit_q;
  logic [GW-1:0]    gap_q;
  logic [CNT_W-1:0] rep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      pat_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort while idle drops a simultaneous start.
          if (start && !abort && (count != '0)) begin
            pat_q   <= pattern;
            shreg_q <= pattern;
            rep_q   <= count;
            bit_q   <= BitLoad;
            state_q <= StShift;
          end
        end

        StShift: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (bit_q == '0) begin
            if (rep_q == RepOne) begin
              state_q <= StDone;
            end else begin
              rep_q <= rep_q - RepOne;
              if (GAP > 0) begin
                gap_q   <= GapLoad;
                state_q <= StGap;
              end else begin
                // Reload from the latched copy for back-to-back repetitions.
                shreg_q <= pat_q;
                bit_q   <= BitLoad;
              end
            end
          end else begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_q   <= bit_q - BitOne;
          end
        end

        StGap: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (gap_q == '0) begin
            shreg_q <= pat_q;
            bit_q   <= BitLoad;
            state_q <= StShift;
          end else begin
            gap_q <= gap_q - GapOne;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs depend only on registered state and the shift register.
  assign out   = (state_q == StShift) && shreg_q[WIDTH-1];
  assign valid = (state_q == StShift);
  assign busy  = (state_q == StShift) || (state_q == StGap);
  assign done  = (state_q == StDone);

endmodule
